// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use, branch-flush and LSU-wait stall sequencer; HAZARD_PERF_COUNTERS_EN adds perf counters
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs1_ID,
  input  logic [3:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [3:0]  rd_EX,
  input  logic        regfile_we_EX,
  input  logic        is_load_EX,
  input  logic        invalid_EX,
  input  logic        branch_taken_EX,
  input  logic        lsu_req_MEM,
  input  logic        lsu_ack_MEM,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        invalid_ID,
  output logic        invalid_EX_inj,
  output logic [15:0] mem_wait_cnt,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] load_use_count,
`endif
  output logic        bus_error
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
  state_t state_q, state_d;
  logic [15:0] mem_wait_cnt_q, mem_wait_cnt_d, cnt_next;
  logic bus_error_q, bus_error_d;
  logic mem_busy, load_use, err, stall_all, flush, bubble;
  assign mem_busy = lsu_req_MEM & ~lsu_ack_MEM;
  assign load_use = is_load_EX & regfile_we_EX & ~invalid_EX & (rd_EX != 4'd0) &
                    ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));
  // next state, wait counter and hazard decode with memory > branch > load-use priority
  always_comb begin
    err = state_q == ERROR;
    stall_all = err | mem_busy;
    flush = ~stall_all & branch_taken_EX;
    bubble = ~stall_all & ~branch_taken_EX & load_use;
    cnt_next = (state_q == RUN) ? 16'd1 : mem_wait_cnt_q + 16'd1;
    state_d = err ? ERROR : mem_busy ? ((cnt_next == TIMEOUT) ? ERROR : MEM_WAIT) : RUN;
    mem_wait_cnt_d = err ? mem_wait_cnt_q : mem_busy ? cnt_next : 16'd0;
    bus_error_d = state_d == ERROR;
  end
  // reset forces bubbles with no stalls so the pipeline drains clean
  always_comb begin
    stall_IF = rst_n & (stall_all | bubble);
    stall_ID = rst_n & (stall_all | bubble);
    stall_EX = rst_n & stall_all;
    stall_MEM = rst_n & stall_all;
    invalid_ID = ~rst_n | err | flush;
    invalid_EX_inj = ~rst_n | err | flush | bubble;
  end
  // state and registered status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      mem_wait_cnt_q <= 16'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end
  assign mem_wait_cnt = mem_wait_cnt_q;
  assign bus_error = bus_error_q;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  logic [31:0] load_use_count_q, load_use_count_d;
  // event counters, wrapping naturally
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_IF};
    flush_count_d = flush_count_q + {31'd0, flush};
    load_use_count_d = load_use_count_q + {31'd0, bubble};
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q <= 32'd0;
      load_use_count_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q <= flush_count_d;
      load_use_count_q <= load_use_count_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_count = flush_count_q;
  assign load_use_count = load_use_count_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench with directed and random hazard stimulus
module tb_pipeline_hazard_controller;
  localparam int TO = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] rs1_ID, rs2_ID, rd_EX;
  logic rs1_used_ID, rs2_used_ID, regfile_we_EX, is_load_EX, invalid_EX;
  logic branch_taken_EX, lsu_req_MEM, lsu_ack_MEM;
  logic stall_IF, stall_ID, stall_EX, stall_MEM, invalid_ID, invalid_EX_inj, bus_error;
  logic [15:0] mem_wait_cnt;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif
  pipeline_hazard_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX),
    .regfile_we_EX(regfile_we_EX), .is_load_EX(is_load_EX), .invalid_EX(invalid_EX),
    .branch_taken_EX(branch_taken_EX), .lsu_req_MEM(lsu_req_MEM), .lsu_ack_MEM(lsu_ack_MEM),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .invalid_ID(invalid_ID), .invalid_EX_inj(invalid_EX_inj), .mem_wait_cnt(mem_wait_cnt),
`ifdef HAZARD_PERF_COUNTERS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .load_use_count(load_use_count),
`endif
    .bus_error(bus_error));
  always #5 clk = ~clk;
  logic [118:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int m_cnt = 0;
  bit m_err = 0;
  logic [31:0] m_sc = 0, m_fc = 0, m_lc = 0;
  function automatic logic [118:0] observed();
    logic [95:0] p;
    p = '0;
`ifdef HAZARD_PERF_COUNTERS_EN
    p = {stall_cycles, flush_count, load_use_count};
`endif
    return {stall_IF, stall_ID, stall_EX, stall_MEM, invalid_ID, invalid_EX_inj, mem_wait_cnt, bus_error, p};
  endfunction
  task automatic go();
    bit busy, lu, fl, bb;
    logic [3:0] o;
    logic [95:0] p;
    busy = lsu_req_MEM && !lsu_ack_MEM;
    lu = is_load_EX && regfile_we_EX && !invalid_EX && rd_EX != 0 &&
         ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
    fl = 0;
    bb = 0;
    if (!rst_n) o = 4'b0011;
    else if (m_err) o = 4'b1111;
    else if (busy) o = 4'b1100;
    else if (branch_taken_EX) begin o = 4'b0011; fl = 1; end
    else if (lu) begin o = 4'b1001; bb = 1; end
    else o = 4'b0000;
    p = '0;
`ifdef HAZARD_PERF_COUNTERS_EN
    p = {m_sc, m_fc, m_lc};
`endif
    exp_q.push_back({o[3], o[3], o[2], o[2], o[1], o[0], 16'(m_cnt), m_err, p});
    if (!rst_n) begin
      m_cnt = 0; m_err = 0; m_sc = 0; m_fc = 0; m_lc = 0;
    end else begin
      m_sc += 32'(o[3]);
      m_fc += 32'(fl);
      m_lc += 32'(bb);
      if (!m_err) begin
        if (busy) begin
          m_cnt++;
          if (m_cnt == TO) m_err = 1;
        end else m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rst_n = 1; rs1_ID = 0; rs2_ID = 0; rd_EX = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    regfile_we_EX = 0; is_load_EX = 0; invalid_EX = 0; branch_taken_EX = 0;
    lsu_req_MEM = 0; lsu_ack_MEM = 0;
  endtask
  task automatic load_use_in(input logic [3:0] rd);
    is_load_EX = 1; regfile_we_EX = 1; rd_EX = rd; rs2_used_ID = 1; rs2_ID = 5;
  endtask
  task automatic rnd();
    rst_n = ($urandom_range(49) != 0);
    rs1_ID = 4'($urandom_range(3)); rs2_ID = 4'($urandom_range(3)); rd_EX = 4'($urandom_range(3));
    rs1_used_ID = 1'($urandom); rs2_used_ID = 1'($urandom); regfile_we_EX = 1'($urandom);
    is_load_EX = 1'($urandom); invalid_EX = ($urandom_range(3) == 0);
    branch_taken_EX = ($urandom_range(4) == 0);
    lsu_req_MEM = ($urandom_range(2) == 0); lsu_ack_MEM = 1'($urandom);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [118:0] e, g;
      e = exp_q.pop_front();
      g = observed();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, g, e);
      end
    end
  end
  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    go(); go();
    idle(); go();
    load_use_in(5); go(); idle(); go();
    load_use_in(0); go(); idle(); go();
    load_use_in(5); invalid_EX = 1; go(); idle(); go();
    branch_taken_EX = 1; go(); idle(); go();
    lsu_req_MEM = 1; go(); go(); go(); lsu_ack_MEM = 1; go(); idle(); go();
    lsu_req_MEM = 1; branch_taken_EX = 1; load_use_in(5); go(); go();
    lsu_ack_MEM = 1; go(); idle(); go();
    lsu_req_MEM = 1; lsu_ack_MEM = 1; go(); idle(); go();
    lsu_req_MEM = 1; repeat (6) go();
    rst_n = 0; go(); idle(); go();
    load_use_in(5); go(); idle(); go(); load_use_in(5); go(); idle(); go();
    branch_taken_EX = 1; go(); idle();
    lsu_req_MEM = 1; go(); go(); go(); lsu_ack_MEM = 1; go(); idle(); go();
    rst_n = 0; go(); idle(); go();
    repeat (3000) begin rnd(); go(); end
    idle(); go();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard and stall sequencer for the 5-stage RV32E pipeline. It drives the per-register `stall` and `invalid` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:

- load-use data hazards (one-cycle bubble),
- taken-branch control hazards (flush of younger instructions),
- multi-cycle data-memory waits, with a timeout that latches a sticky bus error.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of unacknowledged LSU wait cycles before the bus error is raised; legal range 1..65535.

Ports:
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `rs1_ID`, `rs2_ID`  in  4  source register indices of the instruction in ID
- `rs1_used_ID`, `rs2_used_ID`  in  1  the instruction in ID reads rs1 / rs2
- `rd_EX`  in  4  destination register of the instruction in EX
- `regfile_we_EX`  in  1  the instruction in EX writes the register file
- `is_load_EX`  in  1  the instruction in EX is a load
- `invalid_EX`  in  1  the instruction in EX is a bubble
- `branch_taken_EX`  in  1  the branch/jump in EX redirects the PC this cycle
- `lsu_req_MEM`  in  1  the LSU in MEM has an outstanding access
- `lsu_ack_MEM`  in  1  data memory completes the access this cycle
- `stall_IF`  out  1  hold PC
- `stall_ID`  out  1  hold the IF/ID register
- `stall_EX`  out  1  hold the ID/EX register
- `stall_MEM`  out  1  hold the EX/MEM register
- `invalid_ID`  out  1  the instruction entering ID is marked invalid
- `invalid_EX_inj`  out  1  bubble is injected into ID/EX; the ID/EX register's `invalid_ID` input is driven by the OR of this and `invalid_ID`
- `mem_wait_cnt`  out  16  current LSU wait count
- `bus_error`  out  1  sticky; LSU timeout occurred

## Operation

- State machine states: `RUN`, `MEM_WAIT`, `ERROR`.
- Derived terms:
  - `mem_busy = lsu_req_MEM & !lsu_ack_MEM`
  - `load_use = is_load_EX & regfile_we_EX & !invalid_EX & rd_EX != 0 & ((rs1_used_ID & rs1_ID == rd_EX) | (rs2_used_ID & rs2_ID == rd_EX))`
- **RUN:**
  - If `mem_busy`:
    - assert all four stalls,
    - go to `MEM_WAIT`,
    - set `mem_wait_cnt` to 1.
  - Else if `branch_taken_EX`:
    - assert `invalid_ID` and `invalid_EX_inj`; this squashes the two younger instructions,
    - no stalls.
  - Else if `load_use`:
    - assert `stall_IF` and `stall_ID`,
    - assert `invalid_EX_inj`,
    - deassert `stall_EX` and `stall_MEM`.
  - Otherwise all outputs are 0.
- **MEM_WAIT:**
  - All four stalls are asserted while `mem_busy`; `mem_wait_cnt` increments by 1.
  - On `lsu_ack_MEM`:
    - stalls deassert in the same cycle,
    - return to `RUN`,
    - clear `mem_wait_cnt`,
    - evaluate branch and load-use with RUN priority in that same cycle.
  - If `mem_wait_cnt == MEM_TIMEOUT` and no ack arrives: go to `ERROR`.
- **ERROR:**
  - All stalls are 1, `bus_error` is 1, and `invalid_ID` and `invalid_EX_inj` are 1.
  - The block leaves `ERROR` only on reset.
- Priority: memory wait > branch flush > load-use.
  - A taken branch held in EX during a memory stall stays pending, because EX is frozen.
  - The flush fires in the ack cycle.
- `rd_EX == 0` never creates a load-use hazard.
- A bubble in EX (`invalid_EX = 1`) never creates a load-use hazard.
- All outputs except `mem_wait_cnt` and `bus_error` are combinational from the inputs and the state. `mem_wait_cnt` and `bus_error` are registered.

## Timing

- Reset (`rst_n = 0` at a `clk` edge):
  - state becomes `RUN`, `mem_wait_cnt` = 0, `bus_error` = 0.
  - While `rst_n` is low, all stalls are 0 and `invalid_ID` = `invalid_EX_inj` = 1, so the pipeline fills with bubbles.
- Load-use bubble costs exactly 1 cycle. In the next cycle the load is in MEM and `load_use` is naturally 0.
- Branch flush costs 2 cycles of bubbles and 0 stall cycles.
- Memory wait:
  - An ack in the same cycle as the request costs 0 stall cycles.
  - Otherwise the pipeline stalls N cycles for N unacknowledged cycles.
- Timeout: `ERROR` is entered on the clock edge after `MEM_TIMEOUT` consecutive unacknowledged cycles.
- If `rst_n` is asserted mid-wait or in `ERROR`, it takes effect at the next edge regardless of state.

## Configuration

- `HAZARD_PERF_COUNTERS_EN` defined: adds the following outputs, all reset to 0 and wrapping at 2^32:
  - `stall_cycles` out 32: increments every cycle `stall_IF` = 1 outside reset.
  - `flush_count` out 32: increments once per branch flush.
  - `load_use_count` out 32: increments once per load-use bubble.
- Undefined: these ports and registers do not exist.

## Test plan

- Load-use: `is_load_EX = 1`, `regfile_we_EX = 1`, `rd_EX = 5`, `rs2_used_ID = 1`, `rs2_ID = 5` -> `stall_IF = stall_ID = 1`, `invalid_EX_inj = 1`, `stall_EX = 0` for exactly 1 cycle. The same stimulus with `rd_EX = 0` -> no stall.
- Branch: `branch_taken_EX = 1` for 1 cycle -> `invalid_ID = invalid_EX_inj = 1` for that cycle, all stalls 0.
- Memory wait: `lsu_req_MEM = 1` with ack after 3 cycles -> stalls high for 3 cycles, `mem_wait_cnt` reads 1, 2, 3, then 0 after the ack.
- Simultaneous: memory wait + `branch_taken_EX` + load-use -> only stalls until the ack, then the flush takes effect in the ack cycle; no load-use bubble.
- Timeout: `MEM_TIMEOUT = 4`, request never acked -> `bus_error = 1` after 4 wait cycles, stalls stuck at 1. `rst_n = 0` for 1 cycle -> `bus_error = 0`, state `RUN`.
- With `HAZARD_PERF_COUNTERS_EN`: 2 load-use bubbles + 1 branch + a 3-cycle wait -> `stall_cycles = 5`, `flush_count = 1`, `load_use_count = 2`.
